// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding word fetch at a time,
// and holds the returned instruction for decode with redirect/kill handling.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  op,
    output logic [2:0]  func3,
    output logic        func7,
    output logic        misalign_err
);

    typedef enum logic {
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        kill, kill_nxt;
    logic        inst_valid_nxt;
    logic [31:0] inst_nxt, inst_pc_nxt;
    logic        misalign_nxt;

    always_comb begin
        imem_req_valid = (state == S_REQ) & ~redirect_valid & ~(inst_valid & stall);
        imem_req_addr  = pc;
        op             = inst[6:0];
        func3          = inst[14:12];
        func7          = inst[30];
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        kill_nxt       = kill;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        misalign_nxt   = 1'b0;
        inst_valid_nxt = inst_valid & stall;

        if (redirect_valid) begin
            // A fetch still in flight belongs to the old path: drop it now or mark it for discard.
            pc_nxt         = {redirect_pc[31:2], 2'b00};
            inst_valid_nxt = 1'b0;
            misalign_nxt   = |redirect_pc[1:0];
            if (state == S_WAIT) begin
                if (imem_rsp_valid) begin
                    state_nxt = S_REQ;
                    kill_nxt  = 1'b0;
                end else begin
                    kill_nxt  = 1'b1;
                end
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_nxt = S_REQ;
                        kill_nxt  = 1'b0;
                        if (!kill) begin
                            inst_nxt       = imem_rsp_data;
                            inst_pc_nxt    = pc;
                            inst_valid_nxt = 1'b1;
                            pc_nxt         = pc + 32'd4;
                        end
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            inst_valid   <= 1'b0;
            inst         <= '0;
            inst_pc      <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            kill         <= kill_nxt;
            inst_valid   <= inst_valid_nxt;
            inst         <= inst_nxt;
            inst_pc      <= inst_pc_nxt;
            misalign_err <= misalign_nxt;
        end
    end

endmodule
